my_loop_ramp_gen: RTL and testbench
===================================

MY_LOOP_RAMP_GEN -- requirements
Module: my_loop_ramp_gen

Interface
REQ-001 SHALL have parameter DAC_BIT, default 16, ramp output width.
REQ-002 SHALL have parameter ERR_W, default 32, width of the error input, step accumulator and rate output.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_step_sync  input  1  one-cycle pulse, i_err valid the same cycle.
REQ-006 SHALL have port i_rate_sync  input  1  one-cycle pulse, publish rate.
REQ-007 SHALL have port i_ramp_sync  input  1  one-cycle pulse, advance ramp.
REQ-008 SHALL have port i_err  input  ERR_W  signed demodulated error.
REQ-009 SHALL have port i_gain_sel  input  5  loop gain as right-shift count.
REQ-010 SHALL have port i_loop_en  input  1  1 = closed loop, 0 = open loop.
REQ-011 SHALL have port i_const_step  input  ERR_W  signed step used when open loop.
REQ-012 SHALL have port o_rate  output  ERR_W  signed step value published at rate sync.
REQ-013 SHALL have port o_ramp  output  DAC_BIT  ramp top bits to the DAC.
REQ-014 SHALL have port o_ramp_vld  output  1  one-cycle pulse when o_ramp updates.
REQ-015 SHALL have port o_sat  output  1  sticky flag, step accumulator has saturated.
REQ-016 SHALL have port o_overrun  output  1  sticky flag, step sync arrived while busy.
REQ-017 SHALL have port o_cstate  output  2  current state, debug only.

Function
REQ-018 SHALL implement the FSM states IDLE=0, ACCUM=1, WAIT_RATE=2, WAIT_RAMP=3.
REQ-019 In IDLE, when i_step_sync=1, SHALL register err_q = i_err >>> i_gain_sel (arithmetic shift) and go to ACCUM.
REQ-020 In ACCUM (one cycle), if i_loop_en=1 SHALL compute step_acc <= sat(step_acc + err_q) using a 33-bit sum; otherwise SHALL load step_acc <= i_const_step; then go to WAIT_RATE.
REQ-021 sat() SHALL clamp the result to 0x7FFFFFFF or 0x80000000 on overflow and set o_sat.
REQ-022 In WAIT_RATE, when i_rate_sync=1, SHALL set o_rate <= step_acc and go to WAIT_RAMP.
REQ-023 In WAIT_RAMP, when i_ramp_sync=1, SHALL set ramp_acc <= ramp_acc + step_acc modulo 2^ERR_W (wrap, no saturation), pulse o_ramp_vld the next cycle, and go to IDLE.
REQ-024 o_ramp SHALL equal ramp_acc[ERR_W-1 -: DAC_BIT] and change only with ramp_acc.
REQ-025 SHALL meet timing with upstream step/rate/ramp pulses at T, T+2, T+3: ACCUM at T+1, and step_acc valid by T+2.
REQ-026 i_step_sync outside IDLE SHALL be ignored and SHALL set o_overrun.
REQ-027 i_rate_sync outside WAIT_RATE and i_ramp_sync outside WAIT_RAMP SHALL be ignored without a flag.
REQ-028 i_gain_sel values above 31 are not possible; a shift of 31 SHALL yield 0 or -1.
REQ-029 i_gain_sel and i_loop_en SHALL be sampled only in IDLE and ACCUM respectively; mid-cycle changes SHALL take effect on the next step sync.

Reset
REQ-030 On i_rst_n=0, SHALL asynchronously enter IDLE and clear err_q, step_acc, ramp_acc, o_rate, o_ramp, o_ramp_vld, o_sat and o_overrun to 0.
REQ-031 Reset asserted in any state SHALL abort the cycle; no partial update SHALL survive.
REQ-032 Sticky flags SHALL clear only by reset.

Structure
REQ-033 A shared package my_loop_pkg SHALL hold the state enum and the SAT_MAX/SAT_MIN constants.
REQ-034 Saturating addition SHALL live in the sub-module my_sat_add, which is combinational and parameterised by width.

Verification
REQ-035 Closed loop: gain_sel=0, i_err=100 on each of 3 step/rate/ramp triples -> o_rate = 100, 200, 300 and o_ramp accumulator = 100, 300, 600.
REQ-036 Gain: gain_sel=4, i_err=-32 -> err_q=-2; with gain_sel=4, i_err=-1 -> err_q=-1.
REQ-037 Saturation: step_acc=0x7FFFFFF0, i_err=0x100 -> o_rate=0x7FFFFFFF and o_sat=1.
REQ-038 Wrap: ramp_acc=0xFFFF0000, step=0x00020000 -> ramp_acc=0x00010000 and o_ramp=0x0001 with DAC_BIT=16.
REQ-039 Open loop plus overrun: loop_en=0, const_step=5, and a second step sync at T+1 -> o_rate=5, o_overrun=1, and the second pulse is ignored.
REQ-040 Reset in WAIT_RAMP -> all outputs 0 and state IDLE immediately; the next triple starts from step_acc=0.

Source files
------------

// File: rtl/my_loop_pkg.sv
// Shared types and constants for the loop ramp generator: the sequencer
// state encoding and the 32-bit saturation limits.
package my_loop_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCUM     = 2'd1,
    WAIT_RATE = 2'd2,
    WAIT_RAMP = 2'd3
  } state_t;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/my_loop_ramp_gen_if.sv
// Bundle of the sync pulses, loop controls and ramp/status outputs of the
// loop ramp generator. The master drives pulses and controls; the slave is the generator.
interface my_loop_ramp_gen_if #(
  parameter int DAC_BIT = 16,
  parameter int ERR_W   = 32
) (
  input logic clk
);
  // Pulses are single-cycle strobes sampled on the rising clk edge; there is
  // no back-pressure, so a pulse arriving in the wrong state is simply dropped.
  logic               step_sync;
  logic               rate_sync;
  logic               ramp_sync;
  logic [ERR_W-1:0]   err;
  logic [4:0]         gain_sel;
  logic               loop_en;
  logic [ERR_W-1:0]   const_step;
  logic [ERR_W-1:0]   rate;
  logic [DAC_BIT-1:0] ramp;
  logic               ramp_vld;
  logic               sat;
  logic               overrun;
  logic [1:0]         cstate;

  modport master (
    input  clk,
    output step_sync, rate_sync, ramp_sync, err, gain_sel, loop_en, const_step,
    input  rate, ramp, ramp_vld, sat, overrun, cstate
  );

  modport slave (
    input  clk,
    input  step_sync, rate_sync, ramp_sync, err, gain_sel, loop_en, const_step,
    output rate, ramp, ramp_vld, sat, overrun, cstate
  );
endinterface

// File: rtl/my_sat_add.sv
// Combinational signed adder that clamps to the most positive / most
// negative W-bit value on overflow and reports that it clamped.
module my_sat_add #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o,
  output logic                ovf_o
);
  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic [W:0] sum_wide;

  always_comb begin
    sum_wide = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    // Overflow iff the sign-extension bit disagrees with the result sign.
    ovf_o    = sum_wide[W] ^ sum_wide[W-1];
    if (!ovf_o)
      sum_o = sum_wide[W-1:0];
    else if (sum_wide[W])
      sum_o = MIN_V;
    else
      sum_o = MAX_V;
  end
endmodule

// File: rtl/my_loop_ramp_gen.sv
// Loop ramp generator: scales a demodulated error, integrates it into a step,
// publishes the step as a rate and integrates the step into a wrapping ramp.
module my_loop_ramp_gen
  import my_loop_pkg::*;
#(
  parameter int DAC_BIT = 16,
  parameter int ERR_W   = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_step_sync,
  input  logic                      i_rate_sync,
  input  logic                      i_ramp_sync,
  input  logic signed [ERR_W-1:0]   i_err,
  input  logic        [4:0]         i_gain_sel,
  input  logic                      i_loop_en,
  input  logic signed [ERR_W-1:0]   i_const_step,
  output logic signed [ERR_W-1:0]   o_rate,
  output logic        [DAC_BIT-1:0] o_ramp,
  output logic                      o_ramp_vld,
  output logic                      o_sat,
  output logic                      o_overrun,
  output logic        [1:0]         o_cstate
);
  state_t                  state_q;
  logic signed [ERR_W-1:0] err_q;
  logic signed [ERR_W-1:0] step_acc_q;
  logic signed [ERR_W-1:0] ramp_acc_q;
  logic signed [ERR_W-1:0] rate_q;
  logic                    ramp_vld_q;
  logic                    sat_q;
  logic                    overrun_q;

  logic signed [ERR_W-1:0] step_sum_d;
  logic                    step_ovf_d;

  my_sat_add #(.W(ERR_W)) u_sat_add (
    .a_i   (step_acc_q),
    .b_i   (err_q),
    .sum_o (step_sum_d),
    .ovf_o (step_ovf_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      err_q      <= '0;
      step_acc_q <= '0;
      ramp_acc_q <= '0;
      rate_q     <= '0;
      ramp_vld_q <= 1'b0;
      sat_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      ramp_vld_q <= 1'b0;
      // A new step arriving before the previous cycle has finished is dropped.
      if (i_step_sync && (state_q != IDLE))
        overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (i_step_sync) begin
            err_q   <= i_err >>> i_gain_sel;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (i_loop_en) begin
            step_acc_q <= step_sum_d;
            if (step_ovf_d)
              sat_q <= 1'b1;
          end else begin
            step_acc_q <= i_const_step;
          end
          state_q <= WAIT_RATE;
        end
        WAIT_RATE: begin
          if (i_rate_sync) begin
            rate_q  <= step_acc_q;
            state_q <= WAIT_RAMP;
          end
        end
        WAIT_RAMP: begin
          if (i_ramp_sync) begin
            ramp_acc_q <= ramp_acc_q + step_acc_q;
            ramp_vld_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rate     = rate_q;
  assign o_ramp     = ramp_acc_q[ERR_W-1 -: DAC_BIT];
  assign o_ramp_vld = ramp_vld_q;
  assign o_sat      = sat_q;
  assign o_overrun  = overrun_q;
  assign o_cstate   = state_q;
endmodule

// File: tb/tb_my_loop_ramp_gen.sv
// Directed bench for my_loop_ramp_gen: a reference model pushes the expected
// {rate, ramp accumulator} per step/rate/ramp triple; results are popped on o_ramp_vld.
module tb_my_loop_ramp_gen;
  import my_loop_pkg::*;

  localparam int DAC_BIT = 16;
  localparam int ERR_W   = 32;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];

  // Reference model state
  logic [31:0] m_step;
  logic [31:0] m_ramp;
  logic        m_sat;
  logic        m_ovr;

  my_loop_ramp_gen_if #(.DAC_BIT(DAC_BIT), .ERR_W(ERR_W)) bus (.clk(clk));

  my_loop_ramp_gen #(.DAC_BIT(DAC_BIT), .ERR_W(ERR_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_step_sync  (bus.step_sync),
    .i_rate_sync  (bus.rate_sync),
    .i_ramp_sync  (bus.ramp_sync),
    .i_err        (bus.err),
    .i_gain_sel   (bus.gain_sel),
    .i_loop_en    (bus.loop_en),
    .i_const_step (bus.const_step),
    .o_rate       (bus.rate),
    .o_ramp       (bus.ramp),
    .o_ramp_vld   (bus.ramp_vld),
    .o_sat        (bus.sat),
    .o_overrun    (bus.overrun),
    .o_cstate     (bus.cstate)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [31:0] model_sat_add(input logic [31:0] a, input logic [31:0] b,
                                                output logic ovf);
    logic signed [32:0] s;
    s = $signed({a[31], a}) + $signed({b[31], b});
    ovf = (s > 33'sd2147483647) || (s < -33'sd2147483648);
    if (s > 33'sd2147483647)       return SAT_MAX;
    else if (s < -33'sd2147483648) return SAT_MIN;
    else                           return s[31:0];
  endfunction

  task automatic model_reset();
    m_step = '0;
    m_ramp = '0;
    m_sat  = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.step_sync  = 1'b0;
    bus.rate_sync  = 1'b0;
    bus.ramp_sync  = 1'b0;
    bus.err        = '0;
    bus.gain_sel   = '0;
    bus.loop_en    = 1'b1;
    bus.const_step = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Step at T, (optional extra step at T+1), rate at T+2, ramp at T+3.
  task automatic triple(input string tag, input logic [31:0] err, input logic [4:0] gain,
                        input logic loop_en, input logic [31:0] cst, input bit extra_step);
    logic [31:0] eq;
    logic        ovf;
    logic [63:0] e;
    bit          seen;

    eq = $signed(err) >>> gain;
    if (loop_en) begin
      m_step = model_sat_add(m_step, eq, ovf);
      if (ovf) m_sat = 1'b1;
    end else begin
      m_step = cst;
    end
    m_ramp = m_ramp + m_step;
    if (extra_step) m_ovr = 1'b1;
    exp_q.push_back({m_step, m_ramp});

    @(negedge clk);
    bus.step_sync  = 1'b1;
    bus.err        = err;
    bus.gain_sel   = gain;
    bus.loop_en    = loop_en;
    bus.const_step = cst;
    @(negedge clk);
    bus.step_sync  = extra_step;
    bus.err        = 32'h1234_5678;
    @(negedge clk);
    bus.step_sync  = 1'b0;
    bus.rate_sync  = 1'b1;
    @(negedge clk);
    bus.rate_sync  = 1'b0;
    bus.ramp_sync  = 1'b1;
    @(negedge clk);
    bus.ramp_sync  = 1'b0;

    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.ramp_vld === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_vld"}, {63'd0, seen}, 64'd1);

    e = exp_q.pop_front();
    chk({tag, "_rate"},    {32'd0, bus.rate}, {32'd0, e[63:32]});
    chk({tag, "_rampacc"}, {32'd0, dut.ramp_acc_q}, {32'd0, e[31:0]});
    chk({tag, "_oramp"},   {48'd0, bus.ramp}, {48'd0, e[31:16]});
    chk({tag, "_sat"},     {63'd0, bus.sat}, {63'd0, m_sat});
    chk({tag, "_ovr"},     {63'd0, bus.overrun}, {63'd0, m_ovr});
    chk({tag, "_state"},   {62'd0, bus.cstate}, {62'd0, IDLE});
    @(negedge clk);
    chk({tag, "_vld_drop"}, {63'd0, bus.ramp_vld}, 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    chk("rst_rate",    {32'd0, bus.rate}, 64'd0);
    chk("rst_ramp",    {48'd0, bus.ramp}, 64'd0);
    chk("rst_vld",     {63'd0, bus.ramp_vld}, 64'd0);
    chk("rst_sat",     {63'd0, bus.sat}, 64'd0);
    chk("rst_ovr",     {63'd0, bus.overrun}, 64'd0);
    chk("rst_state",   {62'd0, bus.cstate}, 64'd0);
    do_reset();

    // Closed loop integration
    triple("cl1", 32'd100, 5'd0, 1'b1, 32'd0, 1'b0);
    triple("cl2", 32'd100, 5'd0, 1'b1, 32'd0, 1'b0);
    triple("cl3", 32'd100, 5'd0, 1'b1, 32'd0, 1'b0);
    chk("cl_rate300", {32'd0, bus.rate}, 64'd300);
    chk("cl_ramp600", {32'd0, dut.ramp_acc_q}, 64'd600);

    // Gain shifts, including the full 31-bit shift
    do_reset();
    triple("g_m32", 32'hFFFF_FFE0, 5'd4, 1'b1, 32'd0, 1'b0);
    chk("g_m32_const", {32'd0, bus.rate}, {32'd0, 32'hFFFF_FFFE});
    triple("g_m1", 32'hFFFF_FFFF, 5'd4, 1'b1, 32'd0, 1'b0);
    chk("g_m1_const", {32'd0, bus.rate}, {32'd0, 32'hFFFF_FFFD});
    triple("g31_neg", 32'h8000_0000, 5'd31, 1'b1, 32'd0, 1'b0);
    triple("g31_pos", 32'h7FFF_FFFF, 5'd31, 1'b1, 32'd0, 1'b0);
    triple("g_rand", $urandom_range(0, 65535), 5'($urandom_range(0, 8)), 1'b1, 32'd0, 1'b0);

    // Positive saturation
    do_reset();
    triple("sat_pre", 32'd0, 5'd0, 1'b0, 32'h7FFF_FFF0, 1'b0);
    triple("sat_hit", 32'h0000_0100, 5'd0, 1'b1, 32'd0, 1'b0);
    chk("sat_rate_const", {32'd0, bus.rate}, {32'd0, 32'h7FFF_FFFF});
    chk("sat_flag_const", {63'd0, bus.sat}, 64'd1);
    triple("sat_sticky", 32'hFFFF_FF00, 5'd0, 1'b1, 32'd0, 1'b0);

    // Ramp wrap
    do_reset();
    triple("wrap_pre", 32'd0, 5'd0, 1'b0, 32'hFFFF_0000, 1'b0);
    triple("wrap_hit", 32'd0, 5'd0, 1'b0, 32'h0002_0000, 1'b0);
    chk("wrap_acc_const",  {32'd0, dut.ramp_acc_q}, {32'd0, 32'h0001_0000});
    chk("wrap_ramp_const", {48'd0, bus.ramp}, 64'h1);

    // Open loop with an overrunning second step pulse
    do_reset();
    triple("ovr", 32'd0, 5'd0, 1'b0, 32'd5, 1'b1);
    chk("ovr_rate_const", {32'd0, bus.rate}, 64'd5);
    chk("ovr_flag_const", {63'd0, bus.overrun}, 64'd1);

    // Reset asserted while waiting for the ramp pulse
    do_reset();
    triple("pre_abort", 32'd50, 5'd0, 1'b1, 32'd0, 1'b0);
    @(negedge clk);
    bus.step_sync = 1'b1;
    bus.err       = 32'd50;
    @(negedge clk);
    bus.step_sync = 1'b0;
    @(negedge clk);
    bus.rate_sync = 1'b1;
    @(negedge clk);
    bus.rate_sync = 1'b0;
    chk("abort_in_wait_ramp", {62'd0, bus.cstate}, {62'd0, WAIT_RAMP});
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_state", {62'd0, bus.cstate}, 64'd0);
    chk("abort_rate",  {32'd0, bus.rate}, 64'd0);
    chk("abort_ramp",  {48'd0, bus.ramp}, 64'd0);
    chk("abort_acc",   {32'd0, dut.ramp_acc_q}, 64'd0);
    chk("abort_step",  {32'd0, dut.step_acc_q}, 64'd0);
    chk("abort_vld",   {63'd0, bus.ramp_vld}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    triple("post_abort", 32'd7, 5'd0, 1'b1, 32'd0, 1'b0);
    chk("post_abort_const", {32'd0, bus.rate}, 64'd7);

    chk("queue_empty", {32'd0, 32'(exp_q.size())}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
